// File: rtl/pp_seq_multiplier.sv
// Sequential AND-gated partial-product multiplier with a start/busy/done handshake.
// Define PP_SEQ_MULT_SIGNED_EN to build in two's-complement (MULT) support.
module pp_seq_multiplier #(
    parameter int WIDTH        = 32,
    parameter int PP_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int DW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - PP_PER_CYCLE);
    localparam logic [CNT_W-1:0] STEP     = CNT_W'(PP_PER_CYCLE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [DW-1:0]    acc_r;
    logic [DW-1:0]    mcand_r;
    logic [WIDTH-1:0] mplr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] ua_s;
    logic [WIDTH-1:0] ub_s;
    logic [DW-1:0]    sum_s;
    logic [DW-1:0]    fix_s;

`ifdef PP_SEQ_MULT_SIGNED_EN
    logic neg_s;
    logic neg_r;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH-1:0] r;
        if (sgn && v[WIDTH-1]) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign ua_s  = magnitude(a, is_signed);
    assign ub_s  = magnitude(b, is_signed);
    assign neg_s = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    assign fix_s = neg_r ? (~acc_r + {{(DW-1){1'b0}}, 1'b1}) : acc_r;

    // Result sign, captured with the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_r <= 1'b0;
        end else if (state_r == ST_IDLE && start) begin
            neg_r <= neg_s;
        end else begin
            neg_r <= neg_r;
        end
    end
`else
    logic unused_sign_s;

    assign unused_sign_s = is_signed;
    assign ua_s          = a;
    assign ub_s          = b;
    assign fix_s         = acc_r;
`endif

    // Accumulate this cycle's partial products; mplr_r/mcand_r are pre-shifted by the counter.
    always_comb begin
        logic [WIDTH-1:0] bits_s;
        sum_s  = acc_r;
        bits_s = mplr_r;
        for (int j = 0; j < PP_PER_CYCLE; j++) begin
            bits_s = mplr_r >> j;
            if (bits_s[0]) begin
                sum_s = sum_s + (mcand_r << j);
            end else begin
                sum_s = sum_s;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_FIX:  state_nxt_s = ST_DONE;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand shifters, bit counter and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r   <= {DW{1'b0}};
            mcand_r <= {DW{1'b0}};
            mplr_r  <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        acc_r   <= {DW{1'b0}};
                        mcand_r <= {{WIDTH{1'b0}}, ua_s};
                        mplr_r  <= ub_s;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        acc_r   <= acc_r;
                        mcand_r <= mcand_r;
                        mplr_r  <= mplr_r;
                        cnt_r   <= cnt_r;
                    end
                end
                ST_CALC: begin
                    acc_r   <= sum_s;
                    mcand_r <= mcand_r << PP_PER_CYCLE;
                    mplr_r  <= mplr_r >> PP_PER_CYCLE;
                    cnt_r   <= cnt_r + STEP;
                end
                ST_FIX: begin
                    acc_r   <= fix_s;
                    mcand_r <= mcand_r;
                    mplr_r  <= mplr_r;
                    cnt_r   <= cnt_r;
                end
                default: begin
                    acc_r   <= acc_r;
                    mcand_r <= mcand_r;
                    mplr_r  <= mplr_r;
                    cnt_r   <= cnt_r;
                end
            endcase
        end
    end

    // Registered handshake and result; hi/lo only change when leaving FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            hi   <= {WIDTH{1'b0}};
            lo   <= {WIDTH{1'b0}};
        end else begin
            busy <= (state_nxt_s != ST_IDLE);
            done <= (state_nxt_s == ST_DONE);
            if (state_r == ST_FIX) begin
                {hi, lo} <= fix_s;
            end else begin
                hi <= hi;
                lo <= lo;
            end
        end
    end

endmodule

// File: tb/tb_pp_seq_multiplier.sv
// Randomized self-checking bench: one PP_PER_CYCLE=1 and one PP_PER_CYCLE=4 instance share stimulus.
module tb_pp_seq_multiplier;

`ifdef PP_SEQ_MULT_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy1, done1, busy4, done4;
    logic [31:0] hi1, lo1, hi4, lo4;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] prev1 = 64'd0;
    logic [63:0] prev4 = 64'd0;

    always #5 clk = ~clk;

    pp_seq_multiplier #(.WIDTH(32), .PP_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .a(a), .b(b),
        .busy(busy1), .done(done1), .hi(hi1), .lo(lo1)
    );

    pp_seq_multiplier #(.WIDTH(32), .PP_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .a(a), .b(b),
        .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input logic sg);
        logic [63:0] r;
        longint      sx;
        longint      sy;
        r = {32'd0, x} * {32'd0, y};
        if (SIGNED_BUILD && sg) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            r  = 64'(sx * sy);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept in cycle T, then check both instances over cycles T+1..T+37.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic sv);
        logic [63:0] e;
        e         = ref_prod(av, bv, sv);
        a         = av;
        b         = bv;
        is_signed = sv;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 37; k++) begin
            if (k == 1) begin
                a         = $urandom;
                b         = $urandom;
                is_signed = 1'($urandom_range(0, 1));
            end
            check_eq("busy1", 64'(busy1), 64'(k <= 34));
            check_eq("done1", 64'(done1), 64'(k == 34));
            check_eq("busy4", 64'(busy4), 64'(k <= 10));
            check_eq("done4", 64'(done4), 64'(k == 10));
            check_eq("res1", {hi1, lo1}, (k >= 34) ? e : prev1);
            check_eq("res4", {hi4, lo4}, (k >= 10) ? e : prev4);
            tick();
        end
        prev1 = e;
        prev4 = e;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        tick();
        tick();
        check_eq("rst_busy", {62'd0, busy1, busy4}, 64'd0);
        check_eq("rst_done", {62'd0, done1, done4}, 64'd0);
        check_eq("rst_res1", {hi1, lo1}, 64'd0);
        check_eq("rst_res4", {hi4, lo4}, 64'd0);
        rst = 1'b0;
        tick();

        do_op(32'h8888_8888, 32'hFFFF_FFFF, 1'b0);
        check_eq("vec_unsigned", prev1, 64'h8888_8887_7777_7778);
        do_op(32'h8888_8888, 32'hFFFF_FFFF, 1'b1);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_eq("vec_ones", prev1, 64'hFFFF_FFFE_0000_0001);
        do_op(32'd0, 32'hFFFF_FFFF, 1'b1);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b1);

        // start held high: PP=4 instance accepts at T and T+11.
        a         = 32'd7;
        b         = 32'd6;
        is_signed = 1'b0;
        start     = 1'b1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                a = 32'd9;
                b = 32'd5;
            end
            if (k == 12) begin
                start = 1'b0;
            end
            check_eq("b2b_busy4", 64'(busy4), 64'((k <= 10) || (k >= 12 && k <= 21)));
            check_eq("b2b_done4", 64'(done4), 64'(k == 10 || k == 21));
            check_eq("b2b_res4", {hi4, lo4}, (k < 10) ? prev4 : ((k < 21) ? 64'd42 : 64'd45));
            check_eq("b2b_busy1", 64'(busy1), 64'(k <= 34));
            check_eq("b2b_done1", 64'(done1), 64'(k == 34));
            check_eq("b2b_res1", {hi1, lo1}, (k < 34) ? prev1 : 64'd42);
            tick();
        end
        prev1 = 64'd42;
        prev4 = 64'd45;

        // Reset in cycle T+5 of an operation.
        a     = $urandom;
        b     = $urandom;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_busy", {62'd0, busy1, busy4}, 64'd0);
        check_eq("mid_rst_done", {62'd0, done1, done4}, 64'd0);
        check_eq("mid_rst_res1", {hi1, lo1}, 64'd0);
        check_eq("mid_rst_res4", {hi4, lo4}, 64'd0);
        for (int k = 0; k < 40; k++) begin
            check_eq("post_rst_idle", {62'd0, done1, busy1 | done4 | busy4}, 64'd0);
            tick();
        end
        prev1 = 64'd0;
        prev4 = 64'd0;
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

        for (int n = 0; n < 14; n++) begin
            do_op($urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
